// File: rtl/bram_be_dp_clr_if.sv
// Access port bundle for bram_be_dp_clr: one request/response channel per RAM port.
// The master drives requests; the RAM (slave) returns read data and its valid strobe.
interface bram_be_dp_clr_if #(
  parameter int NUM_BYTES  = 4,
  parameter int ADDR_WIDTH = 12
);
  logic                     en;
  logic [NUM_BYTES-1:0]     we;
  logic [ADDR_WIDTH-1:0]    addr;
  logic [8*NUM_BYTES-1:0]   din;
  logic [8*NUM_BYTES-1:0]   dout;
  logic                     valid;

  modport master (output en, we, addr, din, input dout, valid);
  modport slave  (input en, we, addr, din, output dout, valid);
endinterface

// File: rtl/bram_be_dp_clr.sv
// Single-clock true dual-port byte-enable RAM with read-valid strobes and a
// post-reset clear engine that fills every word with a constant byte pattern.
module bram_be_dp_clr #(
  parameter int         NUM_BYTES      = 4,
  parameter int         ADDR_WIDTH     = 12,
  parameter int         READ_LATENCY   = 1,
  parameter bit         WRITE_FIRST    = 1'b0,
  parameter bit         CLEAR_ON_RESET = 1'b1,
  parameter logic [7:0] CLEAR_VALUE    = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  bram_be_dp_clr_if.slave  a,
  bram_be_dp_clr_if.slave  b,
  output logic             init_busy
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef logic [NUM_BYTES-1:0][7:0] word_t;
  typedef enum logic {CLEAR, READY} state_t;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_badLatency
    $error("bram_be_dp_clr: READ_LATENCY must be 1 or 2");
  end

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] clearAddr_q;
  word_t                 mem [DEPTH];

  logic  accA, accB;
  word_t rdA_d, rdB_d;
  word_t doutA1_q, doutB1_q;
  logic  validA1_q, validB1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLEAR_ON_RESET ? CLEAR : READY;
      clearAddr_q <= '0;
    end else if (state_q == CLEAR) begin
      clearAddr_q <= clearAddr_q + ADDR_WIDTH'(1);
      if (&clearAddr_q) state_q <= READY;
    end
  end

  assign init_busy = (state_q == CLEAR);
  assign accA      = a.en && (state_q == READY) && !reset;
  assign accB      = b.en && (state_q == READY) && !reset;

  // Port B lanes are written first so port A overrides any lane both ports hit.
  always_ff @(posedge clk) begin
    if (!reset && state_q == CLEAR) mem[clearAddr_q] <= {NUM_BYTES{CLEAR_VALUE}};
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (accB && b.we[i]) mem[b.addr][i] <= b.din[8*i +: 8];
      if (accA && a.we[i]) mem[a.addr][i] <= a.din[8*i +: 8];
    end
  end

  // Write-first only forwards the port's own write data; the other port's write stays invisible.
  always_comb begin
    rdA_d = mem[a.addr];
    rdB_d = mem[b.addr];
    if (WRITE_FIRST) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (a.we[i]) rdA_d[i] = a.din[8*i +: 8];
        if (b.we[i]) rdB_d[i] = b.din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      doutA1_q  <= '0;
      doutB1_q  <= '0;
      validA1_q <= 1'b0;
      validB1_q <= 1'b0;
    end else begin
      validA1_q <= accA;
      validB1_q <= accB;
      if (accA) doutA1_q <= rdA_d;
      if (accB) doutB1_q <= rdB_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    word_t doutA2_q, doutB2_q;
    logic  validA2_q, validB2_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        doutA2_q  <= '0;
        doutB2_q  <= '0;
        validA2_q <= 1'b0;
        validB2_q <= 1'b0;
      end else begin
        validA2_q <= validA1_q;
        validB2_q <= validB1_q;
        if (validA1_q) doutA2_q <= doutA1_q;
        if (validB1_q) doutB2_q <= doutB1_q;
      end
    end

    assign a.dout  = doutA2_q;
    assign b.dout  = doutB2_q;
    assign a.valid = validA2_q;
    assign b.valid = validB2_q;
  end else begin : g_lat1
    assign a.dout  = doutA1_q;
    assign b.dout  = doutB1_q;
    assign a.valid = validA1_q;
    assign b.valid = validB1_q;
  end

endmodule
